// File: rtl/seven_seg_pkg.sv
// Shared constants for the seven-segment display path: segment bit positions,
// the hex glyph table (active-high, bit 0 = segment a) and the polarity helper.
package seven_seg_pkg;

  localparam int SEG_A = 0;
  localparam int SEG_B = 1;
  localparam int SEG_C = 2;
  localparam int SEG_D = 3;
  localparam int SEG_E = 4;
  localparam int SEG_F = 5;
  localparam int SEG_G = 6;

  // Takes a glyph written left to right as segments a..g and packs it by bit position.
  function automatic logic [6:0] seg_abc(input logic [0:6] s);
    logic [6:0] v;
    v        = '0;
    v[SEG_A] = s[0];
    v[SEG_B] = s[1];
    v[SEG_C] = s[2];
    v[SEG_D] = s[3];
    v[SEG_E] = s[4];
    v[SEG_F] = s[5];
    v[SEG_G] = s[6];
    return v;
  endfunction

  localparam logic [6:0] HEX_GLYPH [16] = '{
    seg_abc(7'b1111110),  // 0
    seg_abc(7'b0110000),  // 1
    seg_abc(7'b1101101),  // 2
    seg_abc(7'b1111001),  // 3
    seg_abc(7'b0110011),  // 4
    seg_abc(7'b1011011),  // 5
    seg_abc(7'b1011111),  // 6
    seg_abc(7'b1110000),  // 7
    seg_abc(7'b1111111),  // 8
    seg_abc(7'b1111011),  // 9
    seg_abc(7'b1110111),  // A
    seg_abc(7'b0011111),  // b
    seg_abc(7'b1001110),  // C
    seg_abc(7'b0111101),  // d
    seg_abc(7'b1001111),  // E
    seg_abc(7'b1000111)   // F
  };

  // Maps an active-high "lit/enabled" bit to the pin level.
  function automatic logic apply_pol(input logic v, input logic active_low);
    return v ^ active_low;
  endfunction

endpackage

// File: rtl/seven_seg_hex.sv
// Combinational nibble-to-glyph decoder; output is active-high, bit 0 = segment a.
module seven_seg_hex
  import seven_seg_pkg::*;
(
  input  logic [3:0] i_nib,
  output logic [6:0] o_seg
);

  assign o_seg = HEX_GLYPH[i_nib];

endmodule

// File: rtl/seven_seg_mux.sv
// Multiplexed N-digit hex display driver: scans one digit per prescaler period,
// shows a frame-stable snapshot of the inputs, with PWM brightness and dead time.
module seven_seg_mux
  import seven_seg_pkg::*;
#(
  parameter int DIGITS         = 4,
  parameter int DIV_W          = 10,
  parameter int BRIGHT_W       = 3,
  parameter int DEAD           = 4,
  parameter bit SEG_ACTIVE_LOW = 1'b1,
  parameter bit DIG_ACTIVE_LOW = 1'b0
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  input  logic [4*DIGITS-1:0]   din,
  input  logic [DIGITS-1:0]     dp_in,
  input  logic                  blank_lz,
  input  logic [BRIGHT_W-1:0]   brightness,
  output logic [6:0]            seg,
  output logic                  dp,
  output logic [DIGITS-1:0]     dig_en,
  output logic                  frame_start
);

  localparam int                IDX_W    = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(DIGITS - 1);
  localparam logic [DIV_W-1:0]  DEAD_V   = DIV_W'(DEAD);

  if (DIGITS < 2 || DIGITS > 8) begin : g_bad_digits
    $error("seven_seg_mux: DIGITS must be in 2..8");
  end
  if (BRIGHT_W > DIV_W) begin : g_bad_bright
    $error("seven_seg_mux: BRIGHT_W must not exceed DIV_W");
  end else if (DEAD >= (1 << (DIV_W - BRIGHT_W))) begin : g_bad_dead
    $error("seven_seg_mux: DEAD must be below 2**(DIV_W-BRIGHT_W)");
  end

  logic [DIV_W-1:0]    r_pre;
  logic [IDX_W-1:0]    r_idx;
  logic [4*DIGITS-1:0] r_sh_din;
  logic [DIGITS-1:0]   r_sh_dp;
  logic                r_sh_blank;

  logic [6:0]          r_seg;
  logic                r_dp;
  logic [DIGITS-1:0]   r_dig;
  logic                r_fs;

  logic                w_slot_end;
  logic                w_snap;
  logic                w_zero_run;
  logic [DIGITS-1:0]   w_blank;
  logic [3:0]          w_nib;
  logic                w_cur_blank;
  logic                w_cur_dp;
  logic [6:0]          w_glyph;
  logic [6:0]          w_seg_hi;
  logic [BRIGHT_W-1:0] w_top;
  logic                w_on;
  logic [DIGITS-1:0]   w_dig_hi;
  logic [6:0]          w_seg_o;
  logic                w_dp_o;
  logic [DIGITS-1:0]   w_dig_o;

  assign w_slot_end = &r_pre;
  assign w_snap     = w_slot_end && (r_idx == LAST_IDX);

  // Shadow registers load on the last cycle of the last slot, so the next
  // digit-0 slot already uses the new frame.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_pre      <= '0;
      r_idx      <= '0;
      r_sh_din   <= '0;
      r_sh_dp    <= '0;
      r_sh_blank <= 1'b0;
    end else begin
      r_pre <= r_pre + 1'b1;
      if (w_slot_end) begin
        r_idx <= (r_idx == LAST_IDX) ? '0 : r_idx + 1'b1;
      end
      if (w_snap) begin
        r_sh_din   <= din;
        r_sh_dp    <= dp_in;
        r_sh_blank <= blank_lz;
      end
    end
  end

  // Walk from the most significant digit down; a digit is blanked while every
  // nibble from the top down to it is zero. Digit 0 always shows.
  always_comb begin
    w_zero_run = 1'b1;
    w_blank    = '0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      w_zero_run = w_zero_run & (r_sh_din[4*i +: 4] == 4'h0);
      w_blank[i] = r_sh_blank & w_zero_run & (i != 0);
    end
  end

  always_comb begin
    w_nib       = '0;
    w_cur_blank = 1'b0;
    w_cur_dp    = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (r_idx == IDX_W'(i)) begin
        w_nib       = r_sh_din[4*i +: 4];
        w_cur_blank = w_blank[i];
        w_cur_dp    = r_sh_dp[i];
      end
    end
  end

  seven_seg_hex u_hex (
    .i_nib (w_nib),
    .o_seg (w_glyph)
  );

  assign w_seg_hi = w_cur_blank ? 7'h00 : w_glyph;
  assign w_top    = r_pre[DIV_W-1 -: BRIGHT_W];
  assign w_on     = (r_pre >= DEAD_V) && ((w_top < brightness) || (&brightness));

  always_comb begin
    w_dig_hi = '0;
    for (int i = 0; i < DIGITS; i++) begin
      w_dig_hi[i] = w_on && (r_idx == IDX_W'(i));
    end
  end

  always_comb begin
    w_seg_o = '0;
    w_dig_o = '0;
    for (int b = 0; b < 7; b++) begin
      w_seg_o[b] = apply_pol(w_seg_hi[b], SEG_ACTIVE_LOW);
    end
    w_dp_o = apply_pol(w_cur_dp, SEG_ACTIVE_LOW);
    for (int i = 0; i < DIGITS; i++) begin
      w_dig_o[i] = apply_pol(w_dig_hi[i], DIG_ACTIVE_LOW);
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_seg <= {7{SEG_ACTIVE_LOW}};
      r_dp  <= SEG_ACTIVE_LOW;
      r_dig <= {DIGITS{DIG_ACTIVE_LOW}};
      r_fs  <= 1'b0;
    end else begin
      r_seg <= w_seg_o;
      r_dp  <= w_dp_o;
      r_dig <= w_dig_o;
      r_fs  <= w_snap;
    end
  end

  assign seg         = r_seg;
  assign dp          = r_dp;
  assign dig_en      = r_dig;
  assign frame_start = r_fs;

endmodule

// File: tb/tb_seven_seg_mux.sv
// Directed bench for seven_seg_mux: two instances share inputs, one with the
// default polarity and one fully inverted, checked cycle by cycle per frame.
module tb_seven_seg_mux;

  localparam logic [6:0] G0 = 7'h3F, G1 = 7'h06, G2 = 7'h5B, G3 = 7'h4F;
  localparam logic [6:0] G4 = 7'h66, G8 = 7'h7F, GA = 7'h77, GB = 7'h7C;
  localparam logic [6:0] GC = 7'h39, GF = 7'h71, BL = 7'h00;

  logic        CLK;
  logic        RST_N;
  logic [15:0] din;
  logic [3:0]  dp_in;
  logic        blank_lz;
  logic [1:0]  brightness;

  logic [6:0]  seg,  seg2;
  logic        dp,   dp2;
  logic [3:0]  dig_en, dig_en2;
  logic        frame_start, frame_start2;

  int n_err;
  int n_checks;

  seven_seg_mux #(
    .DIGITS(4), .DIV_W(4), .BRIGHT_W(2), .DEAD(1),
    .SEG_ACTIVE_LOW(1'b1), .DIG_ACTIVE_LOW(1'b0)
  ) dut (
    .CLK(CLK), .RST_N(RST_N), .din(din), .dp_in(dp_in), .blank_lz(blank_lz),
    .brightness(brightness), .seg(seg), .dp(dp), .dig_en(dig_en),
    .frame_start(frame_start)
  );

  seven_seg_mux #(
    .DIGITS(4), .DIV_W(4), .BRIGHT_W(2), .DEAD(1),
    .SEG_ACTIVE_LOW(1'b0), .DIG_ACTIVE_LOW(1'b1)
  ) dut_inv (
    .CLK(CLK), .RST_N(RST_N), .din(din), .dp_in(dp_in), .blank_lz(blank_lz),
    .brightness(brightness), .seg(seg2), .dp(dp2), .dig_en(dig_en2),
    .frame_start(frame_start2)
  );

  // clock / reset
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_idle(input string tag);
    chk({tag, "/seg"},    {25'd0, seg},     32'h7F);
    chk({tag, "/dp"},     {31'd0, dp},      32'h1);
    chk({tag, "/dig"},    {28'd0, dig_en},  32'h0);
    chk({tag, "/fs"},     {31'd0, frame_start}, 32'h0);
    chk({tag, "/seg_i"},  {25'd0, seg2},    32'h00);
    chk({tag, "/dp_i"},   {31'd0, dp2},     32'h0);
    chk({tag, "/dig_i"},  {28'd0, dig_en2}, 32'hF);
    chk({tag, "/fs_i"},   {31'd0, frame_start2}, 32'h0);
  endtask

  // Checks cycles 1..63 after a frame boundary. Offset j shows the state of
  // pre=(j-1)%16, idx=(j-1)/16 because the outputs are registered.
  task automatic check_frame(input string tag, input logic do_wait,
                             input logic [27:0] exp_seg, input logic [3:0] exp_dp,
                             input int exp_on, input logic chg_en,
                             input logic [15:0] chg_din, output int waited);
    int         on_cnt [4];
    int         p;
    int         d;
    logic       on;
    logic [3:0] edig, edig_i;
    logic [6:0] eseg, eseg_l;
    logic       edp;
    on_cnt = '{0, 0, 0, 0};
    waited = 0;
    if (do_wait) begin
      while (frame_start !== 1'b1 && waited < 200) begin
        @(negedge CLK);
        waited++;
      end
      chk({tag, "/fs_seen"}, {31'd0, frame_start}, 32'h1);
      chk({tag, "/fs_seen_i"}, {31'd0, frame_start2}, 32'h1);
    end
    for (int j = 1; j <= 63; j++) begin
      @(negedge CLK);
      p      = (j - 1) % 16;
      d      = (j - 1) / 16;
      on     = (p >= 1) && (((p / 4) < int'(brightness)) || (brightness == 2'd3));
      edig   = on ? (4'b0001 << d) : 4'b0000;
      edig_i = ~edig;
      eseg   = exp_seg[7*d +: 7];
      eseg_l = ~eseg;
      edp    = exp_dp[d];
      chk({tag, "/seg"},   {25'd0, seg},     {25'd0, eseg_l});
      chk({tag, "/dp"},    {31'd0, dp},      {31'd0, ~edp});
      chk({tag, "/dig"},   {28'd0, dig_en},  {28'd0, edig});
      chk({tag, "/fs"},    {31'd0, frame_start}, 32'h0);
      chk({tag, "/seg_i"}, {25'd0, seg2},    {25'd0, eseg});
      chk({tag, "/dp_i"},  {31'd0, dp2},     {31'd0, edp});
      chk({tag, "/dig_i"}, {28'd0, dig_en2}, {28'd0, edig_i});
      for (int k = 0; k < 4; k++) begin
        if (dig_en[k]) on_cnt[k]++;
      end
      if (chg_en && j == 20) din = chg_din;
    end
    for (int k = 0; k < 3; k++) begin
      chk({tag, "/on_cycles"}, on_cnt[k], exp_on);
    end
  endtask

  int w;
  int on_tbl [4];

  initial begin
    n_err      = 0;
    n_checks   = 0;
    on_tbl     = '{0, 3, 7, 15};
    RST_N      = 1'b0;
    din        = 16'h8888;
    dp_in      = 4'b0000;
    blank_lz   = 1'b0;
    brightness = 2'd3;

    #23;
    check_idle("reset");

    // Until the first snapshot the shadow is zero, so every digit reads "0".
    @(negedge CLK);
    RST_N = 1'b1;
    check_frame("boot", 1'b0, {G0, G0, G0, G0}, 4'b0000, 15, 1'b0, 16'h0, w);
    check_frame("first", 1'b1, {G8, G8, G8, G8}, 4'b0000, 15, 1'b0, 16'h0, w);
    chk("first_fs_cycle", w, 1);

    din = 16'h1A3F;
    check_frame("hex", 1'b1, {G1, GA, G3, GF}, 4'b0000, 15, 1'b1, 16'h2B4C, w);
    check_frame("tear", 1'b1, {G2, GB, G4, GC}, 4'b0000, 15, 1'b0, 16'h0, w);
    chk("tear_fs_back_to_back", w, 1);

    din      = 16'h0040;
    blank_lz = 1'b1;
    check_frame("lz", 1'b1, {BL, BL, G4, G0}, 4'b0000, 15, 1'b0, 16'h0, w);
    dp_in = 4'b1000;
    check_frame("lz_dp", 1'b1, {BL, BL, G4, G0}, 4'b1000, 15, 1'b0, 16'h0, w);
    din   = 16'h0F00;
    dp_in = 4'b0101;
    check_frame("lz_mid", 1'b1, {BL, GF, G0, G0}, 4'b0101, 15, 1'b0, 16'h0, w);
    din   = 16'h0000;
    dp_in = 4'b0000;
    check_frame("lz_all", 1'b1, {BL, BL, BL, G0}, 4'b0000, 15, 1'b0, 16'h0, w);

    din      = 16'h1A3F;
    blank_lz = 1'b0;
    for (int b = 0; b < 4; b++) begin
      brightness = 2'(b);
      check_frame($sformatf("bright%0d", b), 1'b1, {G1, GA, G3, GF}, 4'b0000,
                  on_tbl[b], 1'b0, 16'h0, w);
    end

    // Reset while digit 1 is lit: outputs must drop without waiting for a clock.
    repeat (20) @(negedge CLK);
    chk("pre_rst_dig", {28'd0, dig_en}, 32'h2);
    @(posedge CLK);
    #2;
    RST_N = 1'b0;
    #1;
    check_idle("midrst");
    repeat (3) @(negedge CLK);
    check_idle("midrst_hold");
    RST_N = 1'b1;
    check_frame("reboot", 1'b0, {G0, G0, G0, G0}, 4'b0000, 15, 1'b0, 16'h0, w);
    check_frame("reboot_first", 1'b1, {G1, GA, G3, GF}, 4'b0000, 15, 1'b0, 16'h0, w);
    chk("reboot_fs_cycle", w, 1);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
